hub75_bcm_scan: RTL

HUB75_BCM_SCAN -- requirements
Module: hub75_bcm_scan

---
 rtl/hub75_bcm_scan.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/hub75_bcm_scan.sv
// rtl/hub75_bcm_scan.sv - HUB75 dual-scan panel scanner with binary code modulation
//
// Purpose: walks a dual-scan HUB75 panel row by row. For every row each colour
// bit plane is shifted in (COLS pixels), latched, shown for BASE<<plane cycles
// and followed by GAP blanked cycles. A frame is ROWS rows of BITS planes and
// is never cut short; enable is only looked at between frames.
// Optional feature macro: HUB75_BCM_BRIGHTNESS_EN adds a brightness[2:0] input
// that right-shifts every display period (minimum one cycle).
//
// Ports:
//   clk          sole clock
//   reset        synchronous active-high reset
//   enable       run request, sampled in IDLE and at frame end
//   rd_addrx     pixel-source column address
//   rd_addry     pixel-source row address
//   rd_plane     pixel-source bit-plane index
//   rd_data      {B1,G1,R1,B0,G0,R0}, valid one cycle after the address
//   sclk         panel shift clock
//   latch        panel latch strobe
//   blank        panel output-enable inverse (1 = dark)
//   rgb0, rgb1   {B,G,R} for upper and lower half panel
//   addry        displayed row address
//   frame_start  one-cycle pulse in the first cycle of every frame
//   brightness   (HUB75_BCM_BRIGHTNESS_EN only) display shift, 0 = full

module hub75_bcm_scan #(
  parameter int COLS = 64,
  parameter int ROWS = 32,
  parameter int BITS = 4,
  parameter int BASE = 32,
  parameter int GAP  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
`ifdef HUB75_BCM_BRIGHTNESS_EN
  input  logic [2:0]              brightness,
`endif
  output logic [$clog2(COLS)-1:0] rd_addrx,
  output logic [$clog2(ROWS)-1:0] rd_addry,
  output logic [$clog2(BITS)-1:0] rd_plane,
  input  logic [5:0]              rd_data,
  output logic                    sclk,
  output logic                    latch,
  output logic                    blank,
  output logic [2:0]              rgb0,
  output logic [2:0]              rgb1,
  output logic [$clog2(ROWS)-1:0] addry,
  output logic                    frame_start
);

  localparam int XW       = $clog2(COLS);
  localparam int YW       = $clog2(ROWS);
  localparam int PW       = $clog2(BITS);
  localparam int SHIFT_N  = 2 * COLS + 2;
  localparam int DISP_MAX = BASE << (BITS - 1);
  localparam int M1       = (SHIFT_N > DISP_MAX) ? SHIFT_N : DISP_MAX;
  localparam int CNT_MAX  = (M1 > GAP) ? M1 : GAP;
  // One counter serves SHIFT (up), DISPLAY and GAP (down); sized for the longest.
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SHIFT_LAST     = CW'(SHIFT_N - 1);
  localparam logic [CW-1:0] SHIFT_DATA_END = CW'(2 * COLS);
  localparam logic [CW-1:0] SCLK_FIRST     = CW'(3);
  localparam logic [CW-1:0] GAP_LOAD       = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CW-1:0] BASE_C         = CW'(BASE);
  localparam logic [YW-1:0] ROW_LAST       = YW'(ROWS - 1);
  localparam logic [PW-1:0] PLANE_LAST     = PW'(BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_DISPLAY,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [YW-1:0]   r_row;
  logic [PW-1:0]   r_plane;

  state_t          w_state_n;
  logic [CW-1:0]   w_cnt_n;
  logic [YW-1:0]   w_row_n;
  logic [PW-1:0]   w_plane_n;
  logic            w_fs_n;
  logic            w_adv;
  logic [CW-1:0]   w_disp_full;
  logic [CW-1:0]   w_disp_len;
  logic            w_sclk_n;
  logic [XW-1:0]   w_addrx_n;

  logic [XW-1:0]   r_rd_addrx;
  logic [YW-1:0]   r_rd_addry;
  logic [PW-1:0]   r_rd_plane;
  logic            r_sclk;
  logic            r_latch;
  logic            r_blank;
  logic [2:0]      r_rgb0;
  logic [2:0]      r_rgb1;
  logic [YW-1:0]   r_addry;
  logic            r_fs;

  // Display length for the current plane; brightness is read while in LATCH,
  // which is when this value is loaded into the counter.
  always_comb begin
    w_disp_full = BASE_C << r_plane;
`ifdef HUB75_BCM_BRIGHTNESS_EN
    w_disp_len = w_disp_full >> brightness;
    if (w_disp_len == '0) begin
      w_disp_len = CW'(1);
    end
`else
    w_disp_len = w_disp_full;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
      r_plane <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_row   <= w_row_n;
      r_plane <= w_plane_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_row_n   = r_row;
    w_plane_n = r_plane;
    w_fs_n    = 1'b0;
    w_adv     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_row_n   = '0;
        w_plane_n = '0;
        if (enable) begin
          w_state_n = S_SHIFT;
          w_cnt_n   = '0;
          w_fs_n    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_cnt == SHIFT_LAST) begin
          w_state_n = S_LATCH;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_LATCH: begin
        w_state_n = S_DISPLAY;
        w_cnt_n   = w_disp_len - 1'b1;
      end
      S_DISPLAY: begin
        if (r_cnt == '0) begin
          if (GAP > 0) begin
            w_state_n = S_GAP;
            w_cnt_n   = GAP_LOAD;
          end else begin
            w_adv = 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_adv = 1'b1;
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase

    // End of a plane period: next plane, next row, or end of frame.
    if (w_adv) begin
      w_state_n = S_SHIFT;
      w_cnt_n   = '0;
      if (r_plane == PLANE_LAST) begin
        w_plane_n = '0;
        if (r_row == ROW_LAST) begin
          w_row_n = '0;
          if (enable) begin
            w_fs_n = 1'b1;
          end else begin
            w_state_n = S_IDLE;
          end
        end else begin
          w_row_n = r_row + 1'b1;
        end
      end else begin
        w_plane_n = r_plane + 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state so the registered value lines up
  // with the state the FSM is in during that cycle.
  always_comb begin
    w_sclk_n  = (w_state_n == S_SHIFT) && w_cnt_n[0] && (w_cnt_n >= SCLK_FIRST);
    w_addrx_n = '0;
    if ((w_state_n == S_SHIFT) && (w_cnt_n < SHIFT_DATA_END)) begin
      w_addrx_n = XW'(w_cnt_n >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_addrx <= '0;
      r_rd_addry <= '0;
      r_rd_plane <= '0;
      r_sclk     <= 1'b0;
      r_latch    <= 1'b0;
      r_blank    <= 1'b1;
      r_rgb0     <= '0;
      r_rgb1     <= '0;
      r_addry    <= '0;
      r_fs       <= 1'b0;
    end else begin
      r_rd_addrx <= w_addrx_n;
      r_rd_addry <= w_row_n;
      r_rd_plane <= w_plane_n;
      r_sclk     <= w_sclk_n;
      r_latch    <= (w_state_n == S_LATCH);
      r_blank    <= (w_state_n != S_DISPLAY);
      r_fs       <= w_fs_n;
      if (w_state_n == S_LATCH) begin
        r_addry <= r_row;
      end
      // Odd SHIFT cycles carry the data for the address issued one cycle earlier.
      if ((r_state == S_SHIFT) && r_cnt[0] && (r_cnt < SHIFT_DATA_END)) begin
        r_rgb0 <= rd_data[2:0];
        r_rgb1 <= rd_data[5:3];
      end
    end
  end

  assign rd_addrx    = r_rd_addrx;
  assign rd_addry    = r_rd_addry;
  assign rd_plane    = r_rd_plane;
  assign sclk        = r_sclk;
  assign latch       = r_latch;
  assign blank       = r_blank;
  assign rgb0        = r_rgb0;
  assign rgb1        = r_rgb1;
  assign addry       = r_addry;
  assign frame_start = r_fs;

endmodule
